uart_rx_frame_ctrl: RTL and testbench

- UART receive frame controller. Sits directly downstream of the RX edge/bit counter: it drives the counter's enable and consumes its edge_cnt/bit_cnt outputs.
- Synchronises RX_IN, takes a 3-sample majority vote at mid-bit, and runs the frame FSM (start, data, parity, stop).
- Deserialises LSB-first data and reports a valid byte or the error found.
- Output feeds the RX data synchroniser and system controller.

---
 rtl/uart_rx_frame_ctrl_if.sv | 27 ++
 rtl/uart_rx_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: serial line, frame config, counter handshake and result bundle; brk_det exists only with UART_RX_BREAK_DET_EN
interface uart_rx_frame_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic RX_IN;
  logic [5:0] prescale;
  logic PAR_EN;
  logic PAR_TYP;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic cnt_enable;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic data_valid;
  logic par_err;
  logic stp_err;
  logic busy;
`ifdef UART_RX_BREAK_DET_EN
  logic brk_det;
  modport master (output RX_IN, prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
                  input cnt_enable, P_DATA, data_valid, par_err, stp_err, busy, brk_det);
  modport slave (input RX_IN, prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
                 output cnt_enable, P_DATA, data_valid, par_err, stp_err, busy, brk_det);
`else
  modport master (output RX_IN, prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
                  input cnt_enable, P_DATA, data_valid, par_err, stp_err, busy);
  modport slave (input RX_IN, prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
                 output cnt_enable, P_DATA, data_valid, par_err, stp_err, busy);
`endif
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART RX frame FSM with 3-sample mid-bit majority vote; UART_RX_BREAK_DET_EN adds break detection
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic CLK,
  input logic RST,
  uart_rx_frame_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic s0_q, s0_d, s1_q, s1_d, maj_q, maj_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, pdata_q, pdata_d;
  logic [5:0] pre_q, pre_d;
  logic par_en_q, par_en_d, par_typ_q, par_typ_d, par_fail_q, par_fail_d;
  logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic rx_s, maj, in_frame;
  logic [5:0] mid;
`ifdef UART_RX_BREAK_DET_EN
  logic par_one_q, par_one_d, brk_q, brk_d, bd_q, bd_d;
`endif
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign mid = pre_q >> 1;
  assign in_frame = state_q != IDLE;
  assign maj = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  always_comb begin
    state_d = state_q;
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
    s0_d = (in_frame && bus.edge_cnt == mid - 6'd1) ? rx_s : s0_q;
    s1_d = (in_frame && bus.edge_cnt == mid) ? rx_s : s1_q;
    done_d = in_frame && bus.edge_cnt == mid + 6'd1;
    maj_d = done_d ? maj : maj_q;
    shift_d = shift_q;
    pdata_d = pdata_q;
    pre_d = pre_q;
    par_en_d = par_en_q;
    par_typ_d = par_typ_q;
    par_fail_d = par_fail_q;
    dv_d = 1'b0;
    pe_d = 1'b0;
    se_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    par_one_d = par_one_q;
    brk_d = brk_q && !rx_s;
    bd_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rx_s && bus.prescale inside {6'd8, 6'd16, 6'd32}) begin
        state_d = START;
        pre_d = bus.prescale;
        par_en_d = bus.PAR_EN;
        par_typ_d = bus.PAR_TYP;
        par_fail_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        par_one_d = 1'b0;
`endif
      end
      START: if (done_q) state_d = maj_q ? IDLE : DATA;
      DATA: if (done_q) begin
        shift_d = {maj_q, shift_q[DATA_WIDTH-1:1]};
        if (bus.bit_cnt == 4'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (done_q) begin
        par_fail_d = maj_q != (^shift_q ^ par_typ_q);
`ifdef UART_RX_BREAK_DET_EN
        par_one_d = maj_q;
`endif
        state_d = STOP;
      end
      STOP: if (done_q) begin
        se_d = !maj_q;
        pe_d = maj_q && par_fail_q;
        dv_d = maj_q && !par_fail_q;
        if (dv_d) pdata_d = shift_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_RX_BREAK_DET_EN
    // break replaces the stop error and parks in STOP until the line returns high
    if (state_q == STOP && done_q && !maj_q && shift_q == '0 && !par_one_q) begin
      se_d = 1'b0;
      bd_d = 1'b1;
      brk_d = 1'b1;
      state_d = STOP;
    end
    if (brk_q) state_d = rx_s ? IDLE : STOP;
`endif
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      sync_q <= '1;
      s0_q <= 1'b0;
      s1_q <= 1'b0;
      maj_q <= 1'b0;
      done_q <= 1'b0;
      shift_q <= '0;
      pdata_q <= '0;
      pre_q <= '0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      par_fail_q <= 1'b0;
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_one_q <= 1'b0;
      brk_q <= 1'b0;
      bd_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      maj_q <= maj_d;
      done_q <= done_d;
      shift_q <= shift_d;
      pdata_q <= pdata_d;
      pre_q <= pre_d;
      par_en_q <= par_en_d;
      par_typ_q <= par_typ_d;
      par_fail_q <= par_fail_d;
      dv_q <= dv_d;
      pe_q <= pe_d;
      se_q <= se_d;
`ifdef UART_RX_BREAK_DET_EN
      par_one_q <= par_one_d;
      brk_q <= brk_d;
      bd_q <= bd_d;
`endif
    end
`ifdef UART_RX_BREAK_DET_EN
  assign bus.cnt_enable = in_frame && !brk_q;
  assign bus.brk_det = bd_q;
`else
  assign bus.cnt_enable = in_frame;
`endif
  assign bus.busy = in_frame;
  assign bus.P_DATA = pdata_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err = pe_q;
  assign bus.stp_err = se_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and random frames against a frame-level outcome model
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, bd_cnt = 0, busy_pulse = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_pdata = 8'h00;
  uart_rx_frame_ctrl_if #(.DATA_WIDTH(8)) bus();
  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst)
    if (rst || !bus.cnt_enable) begin
      bus.edge_cnt <= 6'd0;
      bus.bit_cnt <= 4'd0;
    end else if (bus.edge_cnt == bus.prescale - 6'd1) begin
      bus.edge_cnt <= 6'd0;
      bus.bit_cnt <= bus.bit_cnt + 4'd1;
    end else
      bus.edge_cnt <= bus.edge_cnt + 6'd1;
  always @(negedge clk)
    if (!rst) begin
      if (bus.data_valid) begin
        dv_cnt++;
        got_q.push_back(bus.P_DATA);
      end
      if (bus.par_err) pe_cnt++;
      if (bus.stp_err) se_cnt++;
`ifdef UART_RX_BREAK_DET_EN
      if (bus.brk_det) bd_cnt++;
`endif
      if ((bus.data_valid || bus.par_err || bus.stp_err) && bus.busy) busy_pulse++;
    end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.RX_IN = v;
    end
  endtask
  function automatic int build(input logic [7:0] d, input bit pen, input bit pbit, input bit stop, output logic [11:0] b);
    b = '0;
    b[8:1] = d;
    if (pen) begin
      b[9] = pbit;
      b[10] = stop;
      return 11;
    end
    b[9] = stop;
    return 10;
  endfunction
  // one cycle of each bit may be inverted inside the three-sample window around mid-bit
  task automatic send_bits(input logic [11:0] b, input int n, input bit glitch);
    int p = int'(bus.prescale);
    for (int k = 0; k < n; k++) begin
      int g = glitch ? p / 2 - 1 + int'($urandom_range(0, 2)) : -1;
      if (k == 1) begin
        bus.PAR_EN = 1'($urandom);
        bus.PAR_TYP = 1'($urandom);
      end
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        bus.RX_IN = (c == g) ? ~b[k] : b[k];
      end
    end
  endtask
  task automatic model(input logic [7:0] d, input bit pen, input bit ptyp, input bit pbit, input bit stop,
                       output int edv, output int epe, output int ese, output int ebd);
    bit par_ok = !pen || (pbit == (^d ^ ptyp));
`ifdef UART_RX_BREAK_DET_EN
    ebd = (!stop && d == 8'h00 && (!pen || !pbit)) ? 1 : 0;
`else
    ebd = 0;
`endif
    ese = (!stop && ebd == 0) ? 1 : 0;
    epe = (stop && !par_ok) ? 1 : 0;
    edv = (stop && par_ok) ? 1 : 0;
  endtask
  task automatic run_frame(input string tag, input int p, input logic [7:0] d, input bit pen, input bit ptyp,
                           input bit pbit, input bit stop, input bit glitch);
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt, bd0 = bd_cnt;
    int edv, epe, ese, ebd, n;
    logic [11:0] b;
    model(d, pen, ptyp, pbit, stop, edv, epe, ese, ebd);
    bus.prescale = 6'(p);
    bus.PAR_EN = pen;
    bus.PAR_TYP = ptyp;
    n = build(d, pen, pbit, stop, b);
    send_bits(b, n, glitch);
    hold(1'b1, 2 * p + 8);
    if (edv != 0) exp_pdata = d;
    check({tag, " data_valid"}, dv_cnt - dv0, edv);
    check({tag, " par_err"}, pe_cnt - pe0, epe);
    check({tag, " stp_err"}, se_cnt - se0, ese);
    check({tag, " brk_det"}, bd_cnt - bd0, ebd);
    check({tag, " P_DATA"}, bus.P_DATA, exp_pdata);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " cnt_enable"}, bus.cnt_enable, 0);
  endtask
  initial begin
    int dv0, pe0, se0, bd0, n;
    logic [11:0] b;
    bus.RX_IN = 1'b1;
    bus.prescale = 6'd8;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset cnt_enable", bus.cnt_enable, 0);
    check("reset P_DATA", bus.P_DATA, 0);
    check("reset pulses", {bus.data_valid, bus.par_err, bus.stp_err}, 0);
    rst = 1'b0;
    hold(1'b1, 4);
    run_frame("good_a5", 8, 8'hA5, 0, 0, 0, 1, 0);
    run_frame("even_ok_3c", 16, 8'h3C, 1, 0, 0, 1, 0);
    run_frame("even_bad_3c", 16, 8'h3C, 1, 0, 1, 1, 0);
    run_frame("odd_ok_3c", 16, 8'h3C, 1, 1, 1, 1, 0);
    run_frame("stop_81", 32, 8'h81, 0, 0, 0, 0, 0);
    run_frame("stop_par_81", 32, 8'h81, 1, 0, 1, 0, 0);
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    bus.prescale = 6'd16;
    hold(1'b0, 4);
    hold(1'b1, 5);
    check("glitch busy", bus.busy, 1);
    check("glitch cnt_enable", bus.cnt_enable, 1);
    hold(1'b1, 30);
    check("glitch idle", bus.busy, 0);
    check("glitch cnt_enable low", bus.cnt_enable, 0);
    check("glitch pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    run_frame("majority_5a", 8, 8'h5A, 0, 0, 0, 1, 1);
    dv0 = dv_cnt;
    bus.prescale = 6'd8;
    bus.PAR_EN = 1'b0;
    n = build(8'h11, 0, 0, 1, b);
    send_bits(b, n, 0);
    bus.PAR_EN = 1'b0;
    n = build(8'h22, 0, 0, 1, b);
    send_bits(b, n, 0);
    hold(1'b1, 30);
    exp_pdata = 8'h22;
    check("b2b count", dv_cnt - dv0, 2);
    check("b2b first", got_q[got_q.size() - 2], 8'h11);
    check("b2b second", got_q[got_q.size() - 1], 8'h22);
    check("b2b P_DATA", bus.P_DATA, exp_pdata);
    bus.prescale = 6'd12;
    hold(1'b0, 8);
    check("bad prescale busy", bus.busy, 0);
    check("bad prescale cnt_enable", bus.cnt_enable, 0);
    hold(1'b1, 8);
    for (int i = 0; i < 10; i++) begin
      int ps = 8 << $urandom_range(0, 2);
      logic [7:0] d = 8'($urandom);
      bit pen = 1'($urandom);
      bit ptyp = 1'($urandom);
      bit pbit = (^d ^ ptyp) ^ ($urandom_range(0, 3) == 0);
      bit stop = $urandom_range(0, 3) != 0;
      run_frame($sformatf("rand%0d", i), ps, d, pen, ptyp, pbit, stop, 1'($urandom));
    end
`ifdef UART_RX_BREAK_DET_EN
    bd0 = bd_cnt; se0 = se_cnt;
    bus.prescale = 6'd8;
    bus.PAR_EN = 1'b0;
    n = build(8'h00, 0, 0, 0, b);
    send_bits(b, n, 0);
    hold(1'b0, 24);
    check("break brk_det", bd_cnt - bd0, 1);
    check("break stp_err", se_cnt - se0, 0);
    check("break busy held", bus.busy, 1);
    hold(1'b1, 6);
    check("break released", bus.busy, 0);
`else
    run_frame("zero_frame", 8, 8'h00, 0, 0, 0, 0, 0);
`endif
    run_frame("pre_reset_c3", 16, 8'hC3, 0, 0, 0, 1, 0);
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    bus.prescale = 6'd16;
    bus.PAR_EN = 1'b0;
    n = build(8'hFF, 0, 0, 1, b);
    send_bits(b, 4, 0);
    hold(b[4], 8);
    check("midframe busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rst midframe busy", bus.busy, 0);
    check("rst midframe cnt_enable", bus.cnt_enable, 0);
    check("rst midframe P_DATA", bus.P_DATA, 0);
    check("rst midframe pulses", {bus.data_valid, bus.par_err, bus.stp_err}, 0);
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 40);
    check("rst no pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    check("rst stays idle", bus.busy, 0);
    check("pulse while busy", busy_pulse, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
